// File: rtl/unidade_controle_jogo_if.sv
// Bundle of control/status signals between the game control unit and the rest of the circuit.
//   master : control unit side (samples jogar and datapath status, drives control strobes)
//   slave  : datapath/player side (drives jogar and status, samples control strobes)
interface unidade_controle_jogo_if;
    // Player request and datapath status
    logic       jogar;
    logic       jogada_feita;
    logic       jogada_correta;
    logic       endereco_igual_rodada;
    logic       rodada_final;
    // Datapath control strobes and game result flags
    logic       zera_endereco;
    logic       conta_endereco;
    logic       zera_rodada;
    logic       conta_rodada;
    logic       registra_jogada;
    logic       mostra_leds;
    logic       pronto;
    logic       ganhou;
    logic       perdeu;
    logic       timeout;
    logic [3:0] db_estado;

    modport master (
        input  jogar, jogada_feita, jogada_correta, endereco_igual_rodada, rodada_final,
        output zera_endereco, conta_endereco, zera_rodada, conta_rodada, registra_jogada,
        output mostra_leds, pronto, ganhou, perdeu, timeout, db_estado
    );

    modport slave (
        output jogar, jogada_feita, jogada_correta, endereco_igual_rodada, rodada_final,
        input  zera_endereco, conta_endereco, zera_rodada, conta_rodada, registra_jogada,
        input  mostra_leds, pronto, ganhou, perdeu, timeout, db_estado
    );
endinterface

// File: rtl/unidade_controle_jogo.sv
// Control-unit FSM of the memory-sequence game (Moore, registered outputs).
// Shows the stored sequence, waits for player moves with a per-move timeout, compares them
// and advances rounds; flags win, loss and loss-by-timeout.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-low; returns to the idle state with all outputs low
//   jogo  : control/status bundle (master side), see unidade_controle_jogo_if
module unidade_controle_jogo #(
    parameter int unsigned T_LED     = 1000,
    parameter int unsigned T_GAP     = 500,
    parameter int unsigned T_TIMEOUT = 5000
) (
    input  logic                           clock,
    input  logic                           reset,
    unidade_controle_jogo_if.master        jogo
);

    localparam int unsigned TMax0  = (T_LED > T_GAP) ? T_LED : T_GAP;
    localparam int unsigned TMax   = (TMax0 > T_TIMEOUT) ? TMax0 : T_TIMEOUT;
    localparam int unsigned TimerW = $clog2(TMax + 1);

    localparam logic [TimerW-1:0] LedLast  = TimerW'(T_LED - 1);
    localparam logic [TimerW-1:0] GapLast  = TimerW'(T_GAP - 1);
    localparam logic [TimerW-1:0] WaitLast = TimerW'(T_TIMEOUT - 1);

    typedef enum logic [3:0] {
        StInicial    = 4'h0,
        StPrepara    = 4'h1,
        StMostra     = 4'h2,
        StIntervalo  = 4'h3,
        StProxLed    = 4'h4,
        StIniJogadas = 4'h5,
        StEspera     = 4'h6,
        StRegistra   = 4'h7,
        StCompara    = 4'h8,
        StProxJogada = 4'h9,
        StProxRodada = 4'hA,
        StFimGanhou  = 4'hC,
        StFimPerdeu  = 4'hD,
        StFimTimeout = 4'hE
    } state_e;

    state_e            state_q, state_d;
    // The LED and play-timeout timers are never active in the same state, so they share
    // one counter that restarts on every state change.
    logic [TimerW-1:0] timer_q, timer_d;

    logic zera_endereco_q, conta_endereco_q, zera_rodada_q, conta_rodada_q;
    logic registra_jogada_q, mostra_leds_q, pronto_q, ganhou_q, perdeu_q, timeout_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StInicial:    if (jogo.jogar) state_d = StPrepara;
            StPrepara:    state_d = StMostra;
            StMostra:     if (timer_q == LedLast) state_d = StIntervalo;
            StIntervalo: begin
                if (timer_q == GapLast) begin
                    state_d = jogo.endereco_igual_rodada ? StIniJogadas : StProxLed;
                end
            end
            StProxLed:    state_d = StMostra;
            StIniJogadas: state_d = StEspera;
            StEspera: begin
                // A move arriving on the last allowed cycle still counts.
                if (jogo.jogada_feita)          state_d = StRegistra;
                else if (timer_q == WaitLast)   state_d = StFimTimeout;
            end
            StRegistra:   state_d = StCompara;
            StCompara: begin
                if (!jogo.jogada_correta)            state_d = StFimPerdeu;
                else if (jogo.endereco_igual_rodada) state_d = jogo.rodada_final ? StFimGanhou
                                                                                  : StProxRodada;
                else                                 state_d = StProxJogada;
            end
            StProxJogada: state_d = StEspera;
            StProxRodada: state_d = StMostra;
            StFimGanhou, StFimPerdeu, StFimTimeout: begin
                if (jogo.jogar) state_d = StPrepara;
            end
            default:      state_d = StInicial;
        endcase
    end

    always_comb begin
        timer_d = '0;
        if ((state_d == state_q) &&
            ((state_q == StMostra) || (state_q == StIntervalo) || (state_q == StEspera))) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // Outputs are decoded from the next state so the registered copies track the current state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q           <= StInicial;
            timer_q           <= '0;
            zera_endereco_q   <= 1'b0;
            conta_endereco_q  <= 1'b0;
            zera_rodada_q     <= 1'b0;
            conta_rodada_q    <= 1'b0;
            registra_jogada_q <= 1'b0;
            mostra_leds_q     <= 1'b0;
            pronto_q          <= 1'b0;
            ganhou_q          <= 1'b0;
            perdeu_q          <= 1'b0;
            timeout_q         <= 1'b0;
        end else begin
            state_q           <= state_d;
            timer_q           <= timer_d;
            zera_endereco_q   <= (state_d == StPrepara) || (state_d == StIniJogadas) ||
                                 (state_d == StProxRodada);
            conta_endereco_q  <= (state_d == StProxLed) || (state_d == StProxJogada);
            zera_rodada_q     <= (state_d == StPrepara);
            conta_rodada_q    <= (state_d == StProxRodada);
            registra_jogada_q <= (state_d == StRegistra);
            mostra_leds_q     <= (state_d == StMostra);
            pronto_q          <= (state_d == StFimGanhou) || (state_d == StFimPerdeu) ||
                                 (state_d == StFimTimeout);
            ganhou_q          <= (state_d == StFimGanhou);
            perdeu_q          <= (state_d == StFimPerdeu) || (state_d == StFimTimeout);
            timeout_q         <= (state_d == StFimTimeout);
        end
    end

    assign jogo.zera_endereco   = zera_endereco_q;
    assign jogo.conta_endereco  = conta_endereco_q;
    assign jogo.zera_rodada     = zera_rodada_q;
    assign jogo.conta_rodada    = conta_rodada_q;
    assign jogo.registra_jogada = registra_jogada_q;
    assign jogo.mostra_leds     = mostra_leds_q;
    assign jogo.pronto          = pronto_q;
    assign jogo.ganhou          = ganhou_q;
    assign jogo.perdeu          = perdeu_q;
    assign jogo.timeout         = timeout_q;
    assign jogo.db_estado       = state_q;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Bench for unidade_controle_jogo: plans whole games (sequence display, moves, outcomes) from
// the game rules, producing a per-cycle input stimulus and the expected state code; inputs the
// FSM must ignore are randomized. One process drives and checks every cycle.
module tb_unidade_controle_jogo;
    localparam int unsigned TLed = 4;
    localparam int unsigned TGap = 2;
    localparam int unsigned TTo  = 50;
    localparam int X = -1;  // "don't care": randomized input

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    unidade_controle_jogo_if jogo ();

    unidade_controle_jogo #(
        .T_LED     (TLed),
        .T_GAP     (TGap),
        .T_TIMEOUT (TTo)
    ) dut (
        .clock (clock),
        .reset (reset),
        .jogo  (jogo)
    );

    // [9]zera_end [8]conta_end [7]zera_rod [6]conta_rod [5]registra [4]mostra
    // [3]pronto [2]ganhou [1]perdeu [0]timeout
    logic [9:0] dut_outs;
    assign dut_outs = {jogo.zera_endereco, jogo.conta_endereco, jogo.zera_rodada,
                       jogo.conta_rodada, jogo.registra_jogada, jogo.mostra_leds,
                       jogo.pronto, jogo.ganhou, jogo.perdeu, jogo.timeout};

    int tests = 0;
    int fails = 0;

    logic [3:0] exp_st[$];
    logic [4:0] stim[$];     // {jogar, jogada_feita, jogada_correta, endereco_igual_rodada, rodada_final}
    int         gstart[$];
    logic [3:0] obs_db[$];
    logic [9:0] obs_out[$];
    logic [3:0] cur;

    function automatic logic [9:0] expected_outs(input logic [3:0] s);
        case (s)
            4'h1:    return 10'b1010000000;
            4'h2:    return 10'b0000010000;
            4'h4:    return 10'b0100000000;
            4'h5:    return 10'b1000000000;
            4'h7:    return 10'b0000100000;
            4'h9:    return 10'b0100000000;
            4'hA:    return 10'b1001000000;
            4'hC:    return 10'b0000001100;
            4'hD:    return 10'b0000001010;
            4'hE:    return 10'b0000001011;
            default: return 10'b0000000000;
        endcase
    endfunction

    function automatic logic pick(input int v);
        if (v < 0) return logic'($urandom % 2);
        return (v != 0);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp,
                       input int cyc);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic pst(input logic [3:0] st, input int jg, input int jf, input int co,
                       input int eq, input int fi);
        exp_st.push_back(st);
        stim.push_back({pick(jg), pick(jf), pick(co), pick(eq), pick(fi)});
    endtask

    // One full game from the current idle/end state. fail_* marks a wrong move,
    // to_* a missed move; maxw makes the very first move arrive on the last allowed cycle.
    task automatic play(input int fail_r, input int fail_j, input int to_r, input int to_j,
                        input bit maxw);
        int w;
        gstart.push_back(exp_st.size());
        repeat ($urandom_range(3, 0)) pst(cur, 0, X, X, X, X);
        pst(cur, 1, X, X, X, X);
        pst(4'h1, X, X, X, X, X);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i <= r; i++) begin
                repeat (TLed) pst(4'h2, X, X, X, X, X);
                repeat (TGap - 1) pst(4'h3, X, X, X, X, X);
                pst(4'h3, X, X, X, (i == r) ? 1 : 0, X);
                if (i < r) pst(4'h4, X, X, X, X, X);
            end
            pst(4'h5, X, X, X, X, X);
            for (int j = 0; j <= r; j++) begin
                if (r == to_r && j == to_j) begin
                    repeat (TTo) pst(4'h6, X, 0, X, X, X);
                    cur = 4'hE;
                    return;
                end
                if (maxw && r == 0 && j == 0) w = TTo - 1;
                else if ($urandom % 8 == 0)   w = $urandom_range(TTo - 1, 0);
                else                          w = $urandom_range(4, 0);
                repeat (w) pst(4'h6, X, 0, X, X, X);
                pst(4'h6, X, 1, X, X, X);
                pst(4'h7, X, X, X, X, X);
                if (r == fail_r && j == fail_j) begin
                    pst(4'h8, X, X, 0, X, X);
                    cur = 4'hD;
                    return;
                end
                if (j < r) begin
                    pst(4'h8, X, X, 1, 0, X);
                    pst(4'h9, X, X, X, X, X);
                end else if (r == 3) begin
                    pst(4'h8, X, X, 1, 1, 1);
                    cur = 4'hC;
                    return;
                end else begin
                    pst(4'h8, X, X, 1, 1, 0);
                    pst(4'hA, X, X, X, X, X);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fr, fj, kind, k, run, cnt;
        bit found;
        {jogo.jogar, jogo.jogada_feita, jogo.jogada_correta,
         jogo.endereco_igual_rodada, jogo.rodada_final} = 5'b0;

        cur = 4'h0;
        play(X, X, X, X, 1'b0);       // win
        play(2, 1, X, X, 1'b0);       // wrong move, round 2 move 1
        play(X, X, 0, 0, 1'b0);       // timeout on first move
        play(X, X, X, X, 1'b1);       // first move on last allowed cycle
        for (int g = 0; g < 6; g++) begin
            kind = int'($urandom % 3);
            fr   = int'($urandom_range(3, 0));
            fj   = int'($urandom_range(fr, 0));
            if (kind == 0)      play(X, X, X, X, 1'b0);
            else if (kind == 1) play(fr, fj, X, X, 1'b0);
            else                play(X, X, fr, fj, 1'b0);
        end
        gstart.push_back(exp_st.size());
        repeat (3) pst(cur, 0, X, X, X, X);

        // Reset state
        repeat (2) @(negedge clock);
        chk("reset_db_estado", 32'(jogo.db_estado), 32'h0, -1);
        chk("reset_outputs", 32'(dut_outs), 32'h0, -1);

        for (int i = 0; i < exp_st.size(); i++) begin
            @(negedge clock);
            if (i == 0) reset = 1'b1;
            {jogo.jogar, jogo.jogada_feita, jogo.jogada_correta,
             jogo.endereco_igual_rodada, jogo.rodada_final} = stim[i];
            obs_db.push_back(jogo.db_estado);
            obs_out.push_back(dut_outs);
            chk("db_estado", 32'(jogo.db_estado), 32'(exp_st[i]), i);
            chk("outputs", 32'(dut_outs), 32'(expected_outs(exp_st[i])), i);
        end

        // Hand-computed anchors for the planned games
        cnt = 0;
        for (int i = gstart[0]; i < gstart[1]; i++) cnt += int'(obs_out[i][6]);
        chk("g0_conta_rodada_pulses", 32'(cnt), 32'd3, gstart[0]);
        cnt = 0;
        k = gstart[0];
        while (k < gstart[1] && obs_db[k] != 4'h5) begin
            cnt += int'(obs_out[k][4]);
            k++;
        end
        chk("g0_first_show_mostra_cycles", 32'(cnt), 32'd4, k);
        chk("g0_ends_won", 32'(obs_db[gstart[1]]), 32'hC, gstart[1]);
        chk("g1_ends_lost", 32'(obs_db[gstart[2]]), 32'hD, gstart[2]);
        chk("g2_ends_timeout", 32'(obs_db[gstart[3]]), 32'hE, gstart[3]);
        cnt = 0;
        for (int i = gstart[2]; i < gstart[3]; i++) cnt += (obs_db[i] == 4'h6) ? 1 : 0;
        chk("g2_espera_cycles", 32'(cnt), 32'd50, gstart[2]);
        k = gstart[3];
        while (k < gstart[4] && obs_db[k] != 4'h6) k++;
        run = 0;
        while (k < gstart[4] && obs_db[k] == 4'h6) begin
            run++;
            k++;
        end
        chk("g3_first_espera_run", 32'(run), 32'd50, k);
        chk("g3_after_last_cycle_move", 32'((k < gstart[4]) ? obs_db[k] : 4'hF), 32'h7, k);

        // Restart, then asynchronous reset in the middle of the sequence display
        @(negedge clock);
        jogo.jogar = 1'b1;
        @(negedge clock);
        jogo.jogar = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            if (jogo.db_estado == 4'h2) found = 1'b1;
            else @(negedge clock);
        end
        chk("reach_mostra", 32'(found), 32'd1, -1);
        chk("mostra_leds_before_reset", 32'(jogo.mostra_leds), 32'd1, -1);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_db_estado", 32'(jogo.db_estado), 32'h0, -1);
        chk("async_reset_outputs", 32'(dut_outs), 32'h0, -1);
        @(negedge clock);
        reset = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            chk("idle_after_reset", 32'(jogo.db_estado), 32'h0, n);
        end
        jogo.jogar = 1'b1;
        @(negedge clock);
        jogo.jogar = 1'b0;
        chk("restart_after_reset", 32'(jogo.db_estado), 32'h1, -1);
        chk("restart_outputs", 32'(dut_outs), 32'(expected_outs(4'h1)), -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
